// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the source-FIFO arbiter.
// Covers the arbitration mode encodings, the round-robin FSM states and one-hot decoding.
package fifo_arb_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;
    localparam int MAX_CH     = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Index of the set bit; callers guarantee at most one bit is set.
    function automatic int unsigned onehot2idx(input logic [MAX_CH-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (oh[i]) begin
                idx = idx | unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_arb_rr_grant.sv
// Combinational grant picker: owner hold, fixed priority or rotating search from ptr.
// A rotating search starts at ptr and wraps by explicit compare, so any channel count is safe.
module fifo_arb_grant
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_CH = 3,
    parameter  int MODE   = MODE_FIXED,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    input  logic [CH_W-1:0]   owner,
    input  logic              hold,
    output logic [NUM_CH-1:0] grant
);

    logic              found;
    int unsigned       idx;
    logic [CH_W-1:0]   pick;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        pick  = '0;
        if (MODE == MODE_RR && hold) begin
            grant[owner] = 1'b1;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx = unsigned'(k);
                if (MODE == MODE_RR) begin
                    idx = idx + 32'(ptr);
                end
                if (idx >= unsigned'(NUM_CH)) begin
                    idx = idx - unsigned'(NUM_CH);
                end
                pick = CH_W'(idx);
                if (!found && req[pick]) begin
                    grant[pick] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_arb_rr.sv
// N-channel arbiter draining source FIFOs into one downstream FIFO with a 2-cycle
// registered read-to-write pipeline, a channel tag, and optional round-robin bursts.
module fifo_arb_rr
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_CH    = 3,
    parameter  int DATA_W    = 128,
    parameter  int MODE      = MODE_FIXED,
    parameter  int MAX_BURST = 4,
    localparam int CH_W      = $clog2(NUM_CH)
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [NUM_CH*DATA_W-1:0] SRC_DATA,
    input  logic [NUM_CH-1:0]        SRC_EMPTY,
    output logic [NUM_CH-1:0]        SRC_READ,
    input  logic                     FIFO_AFULL,
    output logic [DATA_W-1:0]        FIFO_DATA,
    output logic [CH_W-1:0]          FIFO_TAG,
    output logic                     FIFO_WRITE
);

    localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [7:0]      BURST_MAX = 8'(MAX_BURST);

    arb_state_t        state_q, state_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   owner_q, owner_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [NUM_CH-1:0] sel_d1_q;
    logic [DATA_W-1:0] fifo_data_q, fifo_data_d;
    logic [CH_W-1:0]   fifo_tag_q, fifo_tag_d;
    logic              fifo_write_q, fifo_write_d;

    logic [NUM_CH-1:0] req, grant;
    logic [CH_W-1:0]   owner_inc, arb_ptr, grant_idx, sel_idx;
    logic              hold, burst_end;

    assign req       = ~SRC_EMPTY & {NUM_CH{~FIFO_AFULL}};
    assign owner_inc = (owner_q == LAST_CH) ? '0 : owner_q + CH_W'(1);
    assign hold      = (state_q == BURST) && req[owner_q] && (cnt_q < BURST_MAX);
    // A burst that ends without a stall re-arbitrates in the same cycle from owner+1.
    assign burst_end = (state_q == BURST) && !FIFO_AFULL && !hold;
    assign arb_ptr   = burst_end ? owner_inc : ptr_q;

    fifo_arb_grant #(
        .NUM_CH (NUM_CH),
        .MODE   (MODE)
    ) u_grant (
        .req   (req),
        .ptr   (arb_ptr),
        .owner (owner_q),
        .hold  (hold),
        .grant (grant)
    );

    assign SRC_READ  = grant & {NUM_CH{RESET_N}};
    assign grant_idx = CH_W'(onehot2idx(MAX_CH'(grant)));
    assign sel_idx   = CH_W'(onehot2idx(MAX_CH'(sel_d1_q)));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (MODE == MODE_RR) begin
            case (state_q)
                IDLE: begin
                    if (|grant) begin
                        state_d = BURST;
                        owner_d = grant_idx;
                        cnt_d   = 8'd1;
                    end
                end
                BURST: begin
                    // A stall drops the burst but leaves the pointer where it was.
                    if (FIFO_AFULL) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (hold) begin
                        cnt_d = cnt_q + 8'd1;
                    end else begin
                        ptr_d = owner_inc;
                        if (|grant) begin
                            owner_d = grant_idx;
                            cnt_d   = 8'd1;
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        fifo_write_d = |sel_d1_q;
        fifo_data_d  = fifo_data_q;
        fifo_tag_d   = fifo_tag_q;
        if (|sel_d1_q) begin
            fifo_data_d = SRC_DATA[sel_idx*DATA_W +: DATA_W];
            fifo_tag_d  = sel_idx;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            cnt_q        <= '0;
            sel_d1_q     <= '0;
            fifo_write_q <= 1'b0;
            fifo_data_q  <= '0;
            fifo_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            sel_d1_q     <= grant;
            fifo_write_q <= fifo_write_d;
            fifo_data_q  <= fifo_data_d;
            fifo_tag_q   <= fifo_tag_d;
        end
    end

    assign FIFO_DATA  = fifo_data_q;
    assign FIFO_TAG   = fifo_tag_q;
    assign FIFO_WRITE = fifo_write_q;

endmodule

// File: tb/tb_fifo_arb_rr.sv
// Bench for fifo_arb_rr: three instances (fixed 3ch, RR 3ch burst 2, RR 5ch burst 1)
// driven by queue-based source FIFOs and checked against a rule-level arbitration model.
module tb_fifo_arb_rr;

    localparam int DW = 32;

    typedef struct packed {
        logic [4:0]    rd;
        logic          wr;
        logic [2:0]    tag;
        logic [DW-1:0] data;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [3*DW-1:0] sd0, sd1;
    logic [5*DW-1:0] sd2;
    logic [2:0]      se0, sr0, se1, sr1;
    logic [4:0]      se2, sr2;
    logic            af0, af1, af2, fw0, fw1, fw2;
    logic [DW-1:0]   fd0, fd1, fd2;
    logic [1:0]      ft0, ft1;
    logic [2:0]      ft2;

    fifo_arb_rr #(.NUM_CH(3), .DATA_W(DW), .MODE(0), .MAX_BURST(4)) u_fix (
        .CLK(clk), .RESET_N(rst_n), .SRC_DATA(sd0), .SRC_EMPTY(se0), .SRC_READ(sr0),
        .FIFO_AFULL(af0), .FIFO_DATA(fd0), .FIFO_TAG(ft0), .FIFO_WRITE(fw0));
    fifo_arb_rr #(.NUM_CH(3), .DATA_W(DW), .MODE(1), .MAX_BURST(2)) u_rr3 (
        .CLK(clk), .RESET_N(rst_n), .SRC_DATA(sd1), .SRC_EMPTY(se1), .SRC_READ(sr1),
        .FIFO_AFULL(af1), .FIFO_DATA(fd1), .FIFO_TAG(ft1), .FIFO_WRITE(fw1));
    fifo_arb_rr #(.NUM_CH(5), .DATA_W(DW), .MODE(1), .MAX_BURST(1)) u_rr5 (
        .CLK(clk), .RESET_N(rst_n), .SRC_DATA(sd2), .SRC_EMPTY(se2), .SRC_READ(sr2),
        .FIFO_AFULL(af2), .FIFO_DATA(fd2), .FIFO_TAG(ft2), .FIFO_WRITE(fw2));

    int nch[3]  = '{3, 3, 5};
    int mode[3] = '{0, 1, 1};
    int mb[3]   = '{4, 2, 1};

    logic [DW-1:0] srcq [15][$];
    logic [DW-1:0] dout [15];
    logic          afl [3];
    int            ptr [3], prevg [3], run [3];
    bit            p1v [3], p2v [3];
    int            p1t [3], p2t [3], lastt [3];
    logic [DW-1:0] p1d [3], p2d [3], lastd [3];
    int            seqn, n_cmp, n_bad;

    function automatic string fmt(input obs_t x);
        return $sformatf("rd=%b wr=%b tag=%0d data=%h", x.rd, x.wr, x.tag, x.data);
    endfunction

    task automatic model_reset_all();
        for (int d = 0; d < 3; d++) begin
            ptr[d] = 0; prevg[d] = -1; run[d] = 0;
            p1v[d] = 0; p2v[d] = 0; lastt[d] = 0; lastd[d] = '0;
        end
    endtask

    task automatic push(input int d, input int ch);
        srcq[d*5+ch].push_back({8'(d), 8'(ch), 16'(seqn)});
        seqn++;
    endtask

    task automatic drive(input int d);
        logic [4:0]      e;
        logic [5*DW-1:0] v;
        e = '1;
        v = '0;
        for (int i = 0; i < nch[d]; i++) begin
            e[i] = (srcq[d*5+i].size() == 0);
            v[i*DW +: DW] = dout[d*5+i];
        end
        case (d)
            0: begin se0 = e[2:0]; sd0 = v[3*DW-1:0]; af0 = afl[0]; end
            1: begin se1 = e[2:0]; sd1 = v[3*DW-1:0]; af1 = afl[1]; end
            default: begin se2 = e; sd2 = v; af2 = afl[2]; end
        endcase
    endtask

    task automatic sample(input int d, output obs_t o);
        o = '0;
        case (d)
            0: begin o.rd = {2'b0, sr0}; o.wr = fw0; o.tag = {1'b0, ft0}; o.data = fd0; end
            1: begin o.rd = {2'b0, sr1}; o.wr = fw1; o.tag = {1'b0, ft1}; o.data = fd1; end
            default: begin o.rd = sr2; o.wr = fw2; o.tag = ft2; o.data = fd2; end
        endcase
    endtask

    // One clock of DUT d: entered and left at posedge+1. Returns observed and modelled outputs.
    task automatic run_cycle(input int d, output obs_t o, output obs_t e);
        logic [4:0]    req;
        int            g, idx;
        bit            hold;
        logic [DW-1:0] w;
        drive(d);
        #3;
        sample(d, o);
        if (!rst_n) begin
            ptr[d] = 0; prevg[d] = -1; run[d] = 0;
            p1v[d] = 0; p2v[d] = 0; lastt[d] = 0; lastd[d] = '0;
        end
        req = '0;
        for (int i = 0; i < nch[d]; i++) begin
            req[i] = rst_n && !afl[d] && (srcq[d*5+i].size() != 0);
        end
        g = -1;
        hold = 0;
        if (mode[d] == 0) begin
            for (int i = 0; i < nch[d]; i++) if (g < 0 && req[i]) g = i;
        end else if (afl[d]) begin
            g = -1;
        end else if (prevg[d] >= 0 && req[prevg[d]] && run[d] < mb[d]) begin
            g = prevg[d];
            hold = 1;
        end else begin
            if (prevg[d] >= 0) ptr[d] = (prevg[d] + 1) % nch[d];
            for (int k = 0; k < nch[d]; k++) begin
                idx = (ptr[d] + k) % nch[d];
                if (g < 0 && req[idx]) g = idx;
            end
        end
        run[d] = (g < 0) ? 0 : (hold ? run[d] + 1 : 1);
        prevg[d] = g;
        if (p2v[d]) begin
            lastt[d] = p2t[d];
            lastd[d] = p2d[d];
        end
        e.rd   = (g >= 0) ? 5'(1 << g) : 5'd0;
        e.wr   = p2v[d];
        e.tag  = 3'(lastt[d]);
        e.data = lastd[d];
        if (o.wr) $display("dut%0d write tag=%0d data=%h", d, o.tag, o.data);
        @(posedge clk);
        #1;
        w = '0;
        if (g >= 0) begin
            w = srcq[d*5+g].pop_front();
            dout[d*5+g] = w;
        end
        p2v[d] = p1v[d]; p2t[d] = p1t[d]; p2d[d] = p1d[d];
        p1v[d] = (g >= 0); p1t[d] = g; p1d[d] = w;
        drive(d);
    endtask

    task automatic test_reset();
        obs_t o;
        rst_n = 1'b0;
        srcq[0].push_back(32'hdead_beef);
        drive(0);
        repeat (2) @(posedge clk);
        #4;
        for (int d = 0; d < 3; d++) begin
            sample(d, o);
            n_cmp++;
            if (o !== '0) begin
                n_bad++;
                $display("FAIL reset dut%0d: got %s want all zero", d, fmt(o));
            end
        end
        srcq[0].delete();
        drive(0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_fixed_priority();
        obs_t o, e;
        int   tags[$];
        int   first_rd = -1, first_wr = -1;
        for (int ch = 0; ch < 3; ch++) for (int k = 0; k < 4; k++) push(0, ch);
        for (int c = 0; c < 30; c++) begin
            run_cycle(0, o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL fixed c%0d: got %s want %s", c, fmt(o), fmt(e));
            end
            if (o.rd != 0 && first_rd < 0) first_rd = c;
            if (o.wr) begin
                if (first_wr < 0) first_wr = c;
                tags.push_back(int'(o.tag));
            end
        end
        n_cmp++;
        if (tags.size() != 12) begin
            n_bad++;
            $display("FAIL fixed_count: got %0d writes want 12", tags.size());
        end
        for (int i = 0; i < tags.size() && i < 12; i++) begin
            n_cmp++;
            if (tags[i] != i / 4) begin
                n_bad++;
                $display("FAIL fixed_tag[%0d]: got %0d want %0d", i, tags[i], i / 4);
            end
        end
        n_cmp++;
        if (first_wr - first_rd != 2) begin
            n_bad++;
            $display("FAIL fixed_latency: got %0d want 2", first_wr - first_rd);
        end
    endtask

    task automatic test_rr_burst();
        obs_t o, e;
        int   tags[$];
        int   first_wr = -1, last_wr = -1;
        for (int k = 0; k < 6; k++) begin
            push(1, 0);
            push(1, 2);
        end
        for (int c = 0; c < 20; c++) begin
            run_cycle(1, o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL rr_burst c%0d: got %s want %s", c, fmt(o), fmt(e));
            end
            if (o.wr) begin
                if (first_wr < 0) first_wr = c;
                last_wr = c;
                tags.push_back(int'(o.tag));
            end
        end
        n_cmp++;
        if (tags.size() != 12 || last_wr - first_wr != 11) begin
            n_bad++;
            $display("FAIL rr_burst_span: got %0d writes over %0d cycles want 12 over 12",
                     tags.size(), last_wr - first_wr + 1);
        end
        for (int i = 0; i < tags.size() && i < 12; i++) begin
            n_cmp++;
            if (tags[i] != ((i / 2) % 2) * 2) begin
                n_bad++;
                $display("FAIL rr_tag[%0d]: got %0d want %0d", i, tags[i], ((i / 2) % 2) * 2);
            end
        end
    endtask

    task automatic test_single_word();
        obs_t o, e;
        int   reads = 0, writes = 0, tag = -1;
        push(1, 1);
        for (int c = 0; c < 8; c++) begin
            run_cycle(1, o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL single c%0d: got %s want %s", c, fmt(o), fmt(e));
            end
            if (o.rd[1]) reads++;
            if (o.wr) begin
                writes++;
                tag = int'(o.tag);
            end
        end
        n_cmp++;
        if (reads != 1 || writes != 1 || tag != 1) begin
            n_bad++;
            $display("FAIL single_word: got reads=%0d writes=%0d tag=%0d want 1 1 1", reads, writes, tag);
        end
    endtask

    task automatic test_afull();
        obs_t       o, e;
        int         phase = 0, stall = 0, wr_in_stall = 0;
        logic [4:0] after[$];
        for (int k = 0; k < 8; k++) begin
            push(1, 0);
            push(1, 2);
        end
        for (int c = 0; c < 60; c++) begin
            run_cycle(1, o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL afull c%0d: got %s want %s", c, fmt(o), fmt(e));
            end
            if (phase == 1) begin
                if (o.wr) wr_in_stall++;
                n_cmp++;
                if (o.rd != 0) begin
                    n_bad++;
                    $display("FAIL afull_read: got %b want 00000", o.rd);
                end
                stall--;
                if (stall == 0) begin
                    afl[1] = 1'b0;
                    phase = 2;
                end
            end else if (phase == 2) begin
                if (o.rd != 0) after.push_back(o.rd);
            end else if (o.rd == 5'b00001) begin
                afl[1] = 1'b1;
                stall = 3;
                phase = 1;
            end
        end
        n_cmp++;
        if (wr_in_stall != 2) begin
            n_bad++;
            $display("FAIL afull_inflight: got %0d writes want 2", wr_in_stall);
        end
        n_cmp++;
        if (after.size() < 3 || after[0] != 5'b00001 || after[1] != 5'b00001 || after[2] != 5'b00100) begin
            n_bad++;
            $display("FAIL afull_resume: got %0d grants starting %b want 00001 00001 00100",
                     after.size(), (after.size() > 0) ? after[0] : 5'b0);
        end
        n_cmp++;
        if (srcq[5].size() != 0 || srcq[7].size() != 0) begin
            n_bad++;
            $display("FAIL afull_drain: got %0d/%0d left want 0/0", srcq[5].size(), srcq[7].size());
        end
    endtask

    task automatic test_wrap5();
        obs_t o, e;
        int   n = 0;
        for (int k = 0; k < 3; k++) for (int ch = 0; ch < 5; ch++) push(2, ch);
        for (int c = 0; c < 25; c++) begin
            run_cycle(2, o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL wrap5 c%0d: got %s want %s", c, fmt(o), fmt(e));
            end
            if (o.wr) begin
                n_cmp++;
                if (int'(o.tag) != n % 5) begin
                    n_bad++;
                    $display("FAIL wrap5_tag[%0d]: got %0d want %0d", n, o.tag, n % 5);
                end
                n++;
            end
        end
        n_cmp++;
        if (n != 15) begin
            n_bad++;
            $display("FAIL wrap5_count: got %0d want 15", n);
        end
    endtask

    task automatic test_reset_midstream();
        obs_t o, e;
        for (int k = 0; k < 10; k++) for (int ch = 0; ch < 3; ch++) push(1, ch);
        for (int c = 0; c < 6; c++) begin
            run_cycle(1, o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL midreset_pre c%0d: got %s want %s", c, fmt(o), fmt(e));
            end
        end
        rst_n = 1'b0;
        model_reset_all();
        for (int c = 0; c < 3; c++) begin
            run_cycle(1, o, e);
            n_cmp++;
            if (o !== '0) begin
                n_bad++;
                $display("FAIL midreset_hold c%0d: got %s want all zero", c, fmt(o));
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 60; c++) begin
            run_cycle(1, o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL midreset_post c%0d: got %s want %s", c, fmt(o), fmt(e));
            end
            if (c < 2) begin
                n_cmp++;
                if (o.wr !== 1'b0) begin
                    n_bad++;
                    $display("FAIL midreset_nowrite c%0d: got %b want 0", c, o.wr);
                end
            end
        end
        n_cmp++;
        if (srcq[5].size() + srcq[6].size() + srcq[7].size() != 0) begin
            n_bad++;
            $display("FAIL midreset_drain: got %0d words left want 0",
                     srcq[5].size() + srcq[6].size() + srcq[7].size());
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        for (int d = 0; d < 3; d++) begin
            int pushed = 0, written = 0;
            for (int c = 0; c < 380; c++) begin
                if (c < 300) begin
                    if ($urandom_range(0, 99) < 40) begin
                        push(d, int'($urandom_range(0, nch[d] - 1)));
                        pushed++;
                    end
                    afl[d] = ($urandom_range(0, 99) < 15);
                end else begin
                    afl[d] = 1'b0;
                end
                run_cycle(d, o, e);
                n_cmp++;
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL random dut%0d c%0d: got %s want %s", d, c, fmt(o), fmt(e));
                end
                if (o.wr) written++;
            end
            n_cmp++;
            if (written != pushed) begin
                n_bad++;
                $display("FAIL random_count dut%0d: got %0d writes want %0d", d, written, pushed);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        seqn  = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 15; i++) dout[i] = '0;
        for (int d = 0; d < 3; d++) afl[d] = 1'b0;
        model_reset_all();
        for (int d = 0; d < 3; d++) drive(d);
        test_reset();
        test_fixed_priority();
        test_rr_burst();
        test_single_word();
        test_afull();
        test_wrap5();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
